alu_share_arb: RTL

- Shares one ALU1 instance between two requesters using round-robin arbitration.
- Each requester hands over one operation with a valid/ready handshake. The block registers it, drives the ALU for one CE cycle, waits the ALU latency, and captures RES plus flags.
- The captured result goes back on the granted requester's response channel, held until that requester accepts it.
- Sits between the operation sources and ALU1; the ALU shares the same CLK and RST.

---
 rtl/alu_arb_pkg.sv | 24 ++
 rtl/alu_rr_pick.sv | 23 ++
 rtl/alu_share_arb.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU1 arbiter.
//   arb_state_e : arbiter FSM states
//   FLAG_*      : bit positions inside the captured flag vector {ERR,OFLOW,COUT,G,L,E}
//   CMD_MUL_*   : arithmetic-mode commands that take the longer multiply latency
package alu_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_e;

  localparam int FLAG_W     = 6;
  localparam int FLAG_ERR   = 5;
  localparam int FLAG_OFLOW = 4;
  localparam int FLAG_COUT  = 3;
  localparam int FLAG_G     = 2;
  localparam int FLAG_L     = 1;
  localparam int FLAG_E     = 0;

  localparam logic [3:0] CMD_MUL_A = 4'd9;
  localparam logic [3:0] CMD_MUL_B = 4'd10;

  function automatic logic is_mul(input logic mode, input logic [3:0] cmd);
    return mode && ((cmd == CMD_MUL_A) || (cmd == CMD_MUL_B));
  endfunction

endpackage

// File: rtl/alu_rr_pick.sv
// Combinational 2-way round-robin picker.
//   req_valid_i : per-requester valid
//   pri_i       : requester that wins when both are valid
//   en_i        : grant enable; grant is all-zero when low
//   gnt_o       : one-hot grant (or zero)
//   idx_o       : index of the selected requester (meaningful when gnt_o != 0)
module alu_rr_pick (
  input  logic [1:0] req_valid_i,
  input  logic       pri_i,
  input  logic       en_i,
  output logic [1:0] gnt_o,
  output logic       idx_o
);

  always_comb begin
    idx_o = 1'b0;
    gnt_o = 2'b00;
    if (req_valid_i == 2'b11) idx_o = pri_i;
    else                      idx_o = req_valid_i[1];
    if (en_i && (req_valid_i != 2'b00)) gnt_o = idx_o ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one ALU1 instance between two requesters with round-robin arbitration.
//   CLK/RST            : clock, asynchronous active-high reset
//   REQ_*              : per-requester operation channel (valid/ready, packed operands)
//   RSP_*              : per-requester response channel; RES/FLAGS shared, valid per requester
//   ALU_*  (outputs)   : registered operation driven into ALU1, ALU_CE pulses once per operation
//   ALU_*  (inputs)    : ALU1 result and flags
//   BUSY               : arbiter is not in IDLE
//   GNT_ID             : requester currently owning the ALU
module alu_share_arb
  import alu_arb_pkg::*;
#(
  parameter int INPUT   = 8,
  parameter int ALU_LAT = 1,
  parameter int MUL_LAT = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [1:0]           REQ_VALID,
  output logic [1:0]           REQ_READY,
  input  logic [2*INPUT-1:0]   REQ_OPA,
  input  logic [2*INPUT-1:0]   REQ_OPB,
  input  logic [1:0]           REQ_CIN,
  input  logic [7:0]           REQ_CMD,
  input  logic [1:0]           REQ_MODE,
  input  logic [3:0]           REQ_OPV,
  output logic [1:0]           RSP_VALID,
  input  logic [1:0]           RSP_READY,
  output logic [2*INPUT-1:0]   RSP_RES,
  output logic [FLAG_W-1:0]    RSP_FLAGS,
  output logic [INPUT-1:0]     ALU_OPA,
  output logic [INPUT-1:0]     ALU_OPB,
  output logic                 ALU_CIN,
  output logic                 ALU_CE,
  output logic                 ALU_MODE,
  output logic [3:0]           ALU_CMD,
  output logic [1:0]           ALU_VALID,
  input  logic [2*INPUT-1:0]   ALU_RES,
  input  logic                 ALU_ERR,
  input  logic                 ALU_OFLOW,
  input  logic                 ALU_COUT,
  input  logic                 ALU_G,
  input  logic                 ALU_L,
  input  logic                 ALU_E,
  output logic                 BUSY,
  output logic                 GNT_ID
);

  localparam int MAX_LAT = (MUL_LAT > ALU_LAT) ? MUL_LAT : ALU_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  arb_state_e            state_q;
  logic                  pri_q;
  logic                  gnt_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  ce_q;
  logic [INPUT-1:0]      opa_q;
  logic [INPUT-1:0]      opb_q;
  logic                  cin_q;
  logic                  mode_q;
  logic [3:0]            cmd_q;
  logic [1:0]            opv_q;
  logic [1:0]            rsp_vld_q;
  logic [2*INPUT-1:0]    res_q;
  logic [FLAG_W-1:0]     flags_q;

  logic [1:0]            pick_gnt;
  logic                  pick_idx;

  // Grants are only offered in IDLE; gating with RST keeps REQ_READY at zero
  // while reset is asserted, like every other output.
  alu_rr_pick u_pick (
    .req_valid_i (REQ_VALID),
    .pri_i       (pri_q),
    .en_i        ((state_q == IDLE) && !RST),
    .gnt_o       (pick_gnt),
    .idx_o       (pick_idx)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      pri_q     <= 1'b0;
      gnt_q     <= 1'b0;
      cnt_q     <= '0;
      ce_q      <= 1'b0;
      opa_q     <= '0;
      opb_q     <= '0;
      cin_q     <= 1'b0;
      mode_q    <= 1'b0;
      cmd_q     <= '0;
      opv_q     <= '0;
      rsp_vld_q <= '0;
      res_q     <= '0;
      flags_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_gnt != 2'b00) begin
            opa_q   <= pick_idx ? REQ_OPA[2*INPUT-1:INPUT] : REQ_OPA[INPUT-1:0];
            opb_q   <= pick_idx ? REQ_OPB[2*INPUT-1:INPUT] : REQ_OPB[INPUT-1:0];
            cin_q   <= REQ_CIN[pick_idx];
            mode_q  <= REQ_MODE[pick_idx];
            cmd_q   <= pick_idx ? REQ_CMD[7:4] : REQ_CMD[3:0];
            opv_q   <= pick_idx ? REQ_OPV[3:2] : REQ_OPV[1:0];
            gnt_q   <= pick_idx;
            ce_q    <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          // ALU1 samples CE at the end of this cycle; its output is valid LAT
          // edges later, so the capture happens one edge after that, once the
          // counter has run from LAT down to zero.
          ce_q    <= 1'b0;
          cnt_q   <= is_mul(mode_q, cmd_q) ? CNT_W'(MUL_LAT) : CNT_W'(ALU_LAT);
          state_q <= WAIT;
        end
        WAIT: begin
          if (cnt_q == '0) begin
            res_q                <= ALU_RES;
            flags_q[FLAG_ERR]    <= ALU_ERR;
            flags_q[FLAG_OFLOW]  <= ALU_OFLOW;
            flags_q[FLAG_COUT]   <= ALU_COUT;
            flags_q[FLAG_G]      <= ALU_G;
            flags_q[FLAG_L]      <= ALU_L;
            flags_q[FLAG_E]      <= ALU_E;
            rsp_vld_q            <= gnt_q ? 2'b10 : 2'b01;
            state_q              <= RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          // rsp_vld_q is one-hot on the owner, so a ready from the other
          // requester cannot complete the handshake.
          if ((rsp_vld_q & RSP_READY) != 2'b00) begin
            rsp_vld_q <= 2'b00;
            pri_q     <= ~gnt_q;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign REQ_READY = pick_gnt;
  assign RSP_VALID = rsp_vld_q;
  assign RSP_RES   = res_q;
  assign RSP_FLAGS = flags_q;
  assign ALU_OPA   = opa_q;
  assign ALU_OPB   = opb_q;
  assign ALU_CIN   = cin_q;
  assign ALU_CE    = ce_q;
  assign ALU_MODE  = mode_q;
  assign ALU_CMD   = cmd_q;
  assign ALU_VALID = opv_q;
  assign BUSY      = (state_q != IDLE);
  assign GNT_ID    = gnt_q;

endmodule
